// File: rtl/obstacle_spawner_pkg.sv
// rtl/obstacle_spawner_pkg.sv - shared game constants, FSM state encoding and spawn pick helpers
package obstacle_spawner_pkg;

  // Playfield geometry: the screen is cut into obstacle-wide lanes
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned OBST_W     = 32;
  localparam int unsigned LANE_COUNT = SCREEN_W / OBST_W;

  // Fibonacci feedback taps 16,14,13,11 (bit positions 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ARM    = 2'd2,
    S_ACTIVE = 2'd3
  } state_e;

  // Fold a 0..31 random pick onto 0..19 lanes and convert to a pixel column
  function automatic logic [9:0] lane_x(input logic [4:0] pick);
    logic [4:0] lane;
    lane = (pick < 5'(LANE_COUNT)) ? pick : pick - 5'(LANE_COUNT);
    return 10'(lane) * 10'(OBST_W);
  endfunction

  // Obstacle type 1..3; a zero pick is promoted to type 1
  function automatic logic [1:0] obst_type(input logic [1:0] pick);
    return (pick != 2'd0) ? pick : 2'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR loaded with a seed on reset
module lfsr16
  import obstacle_spawner_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic        feedback_d;

  assign feedback_d = ^(value_q & LFSR_TAPS);
  assign value      = value_q;

  // Shift left every clock; the maximal-length polynomial never reaches zero from a nonzero seed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= seed;
    end else begin
      value_q <= {value_q[14:0], feedback_d};
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - frame-paced obstacle spawner with random lane/type and difficulty ramp
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int unsigned SPAWN_INTERVAL = 60,
  parameter int unsigned MIN_INTERVAL   = 20,
  parameter int unsigned LEVEL_STEP     = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       obstacle_done,
  output logic [1:0] obstacle_trigger,
  output logic [9:0] obstacle_start_x,
  output logic [7:0] spawn_count,
  output logic [6:0] cur_interval
);

  localparam logic [6:0] INIT_INTERVAL  = 7'(SPAWN_INTERVAL);
  localparam logic [6:0] FLOOR_INTERVAL = 7'(MIN_INTERVAL);

  state_e      state_q;
  logic [6:0]  frame_cnt_q;
  logic [6:0]  frame_cnt_d;
  logic [1:0]  trigger_q;
  logic [9:0]  start_x_q;
  logic [7:0]  spawn_count_q;
  logic [7:0]  spawn_count_d;
  logic [6:0]  cur_interval_q;
  logic        level_up;
  logic [15:0] lfsr_value;
  logic        unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clock (CLOCK_50),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  // Only the low seven LFSR bits feed the lane and type picks
  assign unused_lfsr_hi = ^lfsr_value[15:7];

  // Next frame count, next spawn number, and whether that spawn closes a difficulty level
  always_comb begin
    frame_cnt_d   = frame_cnt_q + 7'd1;
    spawn_count_d = spawn_count_q + 8'd1;
    level_up      = ((32'(spawn_count_d) % LEVEL_STEP) == 32'd0) &&
                    (cur_interval_q > FLOOR_INTERVAL);
  end

  // Spawn FSM; enable low overrides every state, reset clears everything without a clock
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      trigger_q      <= '0;
      start_x_q      <= '0;
      spawn_count_q  <= '0;
      cur_interval_q <= INIT_INTERVAL;
    end else if (!enable) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      trigger_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_cnt_q <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (frame_cnt_d == cur_interval_q) begin
              frame_cnt_q <= '0;
              state_q     <= S_ARM;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
        end
        S_ARM: begin
          start_x_q     <= lane_x(lfsr_value[6:2]);
          trigger_q     <= obst_type(lfsr_value[1:0]);
          spawn_count_q <= spawn_count_d;
          if (level_up) begin
            cur_interval_q <= cur_interval_q - 7'd1;
          end
          state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (obstacle_done) begin
            trigger_q <= '0;
            state_q   <= S_WAIT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign obstacle_trigger = trigger_q;
  assign obstacle_start_x = start_x_q;
  assign spawn_count      = spawn_count_q;
  assign cur_interval     = cur_interval_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - directed self-checking bench for obstacle_spawner
module tb_obstacle_spawner;
  import obstacle_spawner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic        ft = 1'b0;
  logic        od = 1'b0;
  logic [1:0]  trig_a, trig_b;
  logic [9:0]  sx_a, sx_b;
  logic [7:0]  cnt_a, cnt_b;
  logic [6:0]  intv_a, intv_b;
  logic [15:0] force_val;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Short-interval instance for spawn/lane/enable/reset scenarios
  obstacle_spawner #(.SPAWN_INTERVAL(4), .MIN_INTERVAL(2), .LEVEL_STEP(8), .LFSR_SEED(16'hACE1)) dut_a (
    .CLOCK_50(clk), .reset(rst_n), .enable(en_a), .frame_tick(ft), .obstacle_done(od),
    .obstacle_trigger(trig_a), .obstacle_start_x(sx_a), .spawn_count(cnt_a), .cur_interval(intv_a)
  );

  // Difficulty-ramp instance
  obstacle_spawner #(.SPAWN_INTERVAL(22), .MIN_INTERVAL(20), .LEVEL_STEP(8), .LFSR_SEED(16'hACE1)) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .enable(en_b), .frame_tick(ft), .obstacle_done(od),
    .obstacle_trigger(trig_b), .obstacle_start_x(sx_b), .spawn_count(cnt_b), .cur_interval(intv_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each frame tick is a one-cycle pulse followed by one quiet cycle
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ft = 1'b1;
      step();
      ft = 1'b0;
      step();
    end
  endtask

  task automatic done_pulse();
    od = 1'b1;
    step();
    od = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL reset_trig: got %0d want 0", trig_a); end
    n_vec++; if (sx_a !== 10'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", sx_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    n_vec++; if (intv_a !== 7'd4) begin n_bad++; $display("FAIL reset_interval_a: got %0d want 4", intv_a); end
    n_vec++; if (intv_b !== 7'd22) begin n_bad++; $display("FAIL reset_interval_b: got %0d want 22", intv_b); end
    n_vec++; if (dut_a.state_q !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut_a.state_q, S_IDLE); end
    n_vec++; if (dut_a.lfsr_value !== 16'hACE1) begin n_bad++; $display("FAIL reset_lfsr: got %h want ace1", dut_a.lfsr_value); end
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (dut_a.lfsr_value !== 16'h59C3) begin n_bad++; $display("FAIL lfsr_step1: got %h want 59c3", dut_a.lfsr_value); end
    n_vec++; if (dut_a.state_q !== S_IDLE) begin n_bad++; $display("FAIL idle_hold: got %0d want %0d", dut_a.state_q, S_IDLE); end
  endtask

  task automatic test_first_spawn();
    en_a = 1'b1;
    ft = 1'b1;   // tick in IDLE must not count
    step();
    ft = 1'b0;
    step();
    n_vec++; if (dut_a.state_q !== S_WAIT) begin n_bad++; $display("FAIL enter_wait: got %0d want %0d", dut_a.state_q, S_WAIT); end
    ticks(3);
    n_vec++; if (dut_a.state_q !== S_WAIT) begin n_bad++; $display("FAIL wait_after_3: got %0d want %0d", dut_a.state_q, S_WAIT); end
    ft = 1'b1;
    step();
    ft = 1'b0;
    n_vec++; if (dut_a.state_q !== S_ARM) begin n_bad++; $display("FAIL arm_after_4: got %0d want %0d", dut_a.state_q, S_ARM); end
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL arm_trig: got %0d want 0", trig_a); end
    step();
    n_vec++; if (dut_a.state_q !== S_ACTIVE) begin n_bad++; $display("FAIL active1: got %0d want %0d", dut_a.state_q, S_ACTIVE); end
    n_vec++; if (trig_a == 2'd0) begin n_bad++; $display("FAIL first_trig: got %0d want 1..3", trig_a); end
    n_vec++; if ((sx_a % 32) != 0 || sx_a > 10'd608) begin n_bad++; $display("FAIL first_x: got %0d want multiple of 32 <= 608", sx_a); end
    n_vec++; if (cnt_a !== 8'd1) begin n_bad++; $display("FAIL first_count: got %0d want 1", cnt_a); end
    done_pulse();
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL first_done_trig: got %0d want 0", trig_a); end
  endtask

  task automatic test_active_hold();
    done_pulse();   // ignored in WAIT
    force_val = 16'h005C;
    force dut_a.lfsr_value = force_val;
    ticks(4);
    release dut_a.lfsr_value;
    n_vec++; if (sx_a !== 10'd96) begin n_bad++; $display("FAIL forced_x: got %0d want 96", sx_a); end
    n_vec++; if (trig_a !== 2'd1) begin n_bad++; $display("FAIL forced_trig: got %0d want 1", trig_a); end
    n_vec++; if (cnt_a !== 8'd2) begin n_bad++; $display("FAIL forced_count: got %0d want 2", cnt_a); end
    ticks(100);
    n_vec++; if (sx_a !== 10'd96) begin n_bad++; $display("FAIL hold_x: got %0d want 96", sx_a); end
    n_vec++; if (trig_a !== 2'd1) begin n_bad++; $display("FAIL hold_trig: got %0d want 1", trig_a); end
    n_vec++; if (cnt_a !== 8'd2) begin n_bad++; $display("FAIL hold_count: got %0d want 2", cnt_a); end
    n_vec++; if (dut_a.state_q !== S_ACTIVE) begin n_bad++; $display("FAIL hold_state: got %0d want %0d", dut_a.state_q, S_ACTIVE); end
    done_pulse();
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL done_trig: got %0d want 0", trig_a); end
    n_vec++; if (dut_a.state_q !== S_WAIT) begin n_bad++; $display("FAIL done_state: got %0d want %0d", dut_a.state_q, S_WAIT); end
  endtask

  task automatic test_lane_select();
    logic [15:0] vals [4];
    logic [9:0]  exp_x [4];
    logic [1:0]  exp_t [4];
    vals  = '{16'h8013, 16'h407E, 16'h204D, 16'h1050};
    exp_x = '{10'd128, 10'd352, 10'd608, 10'd0};
    exp_t = '{2'd3, 2'd2, 2'd1, 2'd1};
    for (int k = 0; k < 4; k++) begin
      force_val = vals[k];
      force dut_a.lfsr_value = force_val;
      ticks(4);
      release dut_a.lfsr_value;
      n_vec++; if (sx_a !== exp_x[k]) begin n_bad++; $display("FAIL lane_x[%0d]: got %0d want %0d", k, sx_a, exp_x[k]); end
      n_vec++; if (trig_a !== exp_t[k]) begin n_bad++; $display("FAIL lane_type[%0d]: got %0d want %0d", k, trig_a, exp_t[k]); end
      n_vec++; if (cnt_a !== 8'(k + 3)) begin n_bad++; $display("FAIL lane_count[%0d]: got %0d want %0d", k, cnt_a, k + 3); end
      done_pulse();
      n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL lane_done[%0d]: got %0d want 0", k, trig_a); end
    end
  endtask

  task automatic test_enable_drop();
    ticks(4);
    n_vec++; if (dut_a.state_q !== S_ACTIVE) begin n_bad++; $display("FAIL pre_drop_state: got %0d want %0d", dut_a.state_q, S_ACTIVE); end
    en_a = 1'b0;
    od = 1'b1;
    step();
    od = 1'b0;
    n_vec++; if (dut_a.state_q !== S_IDLE) begin n_bad++; $display("FAIL drop_state: got %0d want %0d", dut_a.state_q, S_IDLE); end
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL drop_trig: got %0d want 0", trig_a); end
    n_vec++; if (intv_a !== 7'd4) begin n_bad++; $display("FAIL drop_interval: got %0d want 4", intv_a); end
    n_vec++; if (cnt_a !== 8'd7) begin n_bad++; $display("FAIL drop_count: got %0d want 7", cnt_a); end
    ticks(5);
    n_vec++; if (dut_a.state_q !== S_IDLE) begin n_bad++; $display("FAIL disabled_idle: got %0d want %0d", dut_a.state_q, S_IDLE); end
    en_a = 1'b1;
    step();
    ticks(4);
    n_vec++; if (cnt_a !== 8'd8) begin n_bad++; $display("FAIL spawn8_count: got %0d want 8", cnt_a); end
    n_vec++; if (intv_a !== 7'd3) begin n_bad++; $display("FAIL spawn8_interval: got %0d want 3", intv_a); end
    done_pulse();
  endtask

  task automatic test_async_reset();
    ticks(2);
    n_vec++; if (dut_a.state_q !== S_WAIT) begin n_bad++; $display("FAIL short_wait: got %0d want %0d", dut_a.state_q, S_WAIT); end
    ticks(1);
    n_vec++; if (trig_a == 2'd0) begin n_bad++; $display("FAIL pre_reset_trig: got %0d want 1..3", trig_a); end
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (trig_a !== 2'd0) begin n_bad++; $display("FAIL async_trig: got %0d want 0", trig_a); end
    n_vec++; if (sx_a !== 10'd0) begin n_bad++; $display("FAIL async_x: got %0d want 0", sx_a); end
    n_vec++; if (cnt_a !== 8'd0) begin n_bad++; $display("FAIL async_count: got %0d want 0", cnt_a); end
    n_vec++; if (intv_a !== 7'd4) begin n_bad++; $display("FAIL async_interval: got %0d want 4", intv_a); end
    n_vec++; if (dut_a.state_q !== S_IDLE) begin n_bad++; $display("FAIL async_state: got %0d want %0d", dut_a.state_q, S_IDLE); end
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (dut_a.state_q !== S_WAIT) begin n_bad++; $display("FAIL post_reset_wait: got %0d want %0d", dut_a.state_q, S_WAIT); end
    en_a = 1'b0;
    step();
  endtask

  task automatic test_difficulty();
    int need;
    int exp_after;
    en_b = 1'b1;
    step();
    for (int s = 1; s <= 40; s++) begin
      need      = (s <= 8) ? 22 : (s <= 16) ? 21 : 20;
      exp_after = (s < 8) ? 22 : (s < 16) ? 21 : 20;
      ticks(need - 1);
      n_vec++; if (dut_b.state_q !== S_WAIT) begin n_bad++; $display("FAIL diff_latency[%0d]: got %0d want %0d", s, dut_b.state_q, S_WAIT); end
      ticks(1);
      n_vec++; if (cnt_b !== 8'(s)) begin n_bad++; $display("FAIL diff_count[%0d]: got %0d want %0d", s, cnt_b, s); end
      n_vec++; if (intv_b !== 7'(exp_after)) begin n_bad++; $display("FAIL diff_interval[%0d]: got %0d want %0d", s, intv_b, exp_after); end
      done_pulse();
    end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_active_hold();
    test_lane_select();
    test_enable_drop();
    test_async_reset();
    test_difficulty();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, want finish before 2000000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter SPAWN_INTERVAL, default 60, meaning initial frames between obstacle retirement and the next spawn.
REQ-002 SHALL have parameter MIN_INTERVAL, default 20, meaning the floor of the spawn interval in frames.
REQ-003 SHALL have parameter LEVEL_STEP, default 8, meaning the number of spawns per 1-frame interval decrement.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR value after reset.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: game running; low holds the block idle.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-009 SHALL have port obstacle_done, input, 1 bit: one-cycle pulse when the current obstacle leaves the screen.
REQ-010 SHALL have port obstacle_trigger, output, 2 bits: obstacle type 1..3; 0 means no obstacle; held for the obstacle lifetime.
REQ-011 SHALL have port obstacle_start_x, output, 10 bits: spawn column in pixels.
REQ-012 SHALL have port spawn_count, output, 8 bits: number of spawns since reset, wrapping.
REQ-013 SHALL have port cur_interval, output, 7 bits: current spawn interval in frames.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ARM and ACTIVE.
REQ-015 IDLE: outputs hold; frame counter = 0; enable=1 -> WAIT next cycle.
REQ-016 WAIT: frame counter increments on each frame_tick; on the tick that makes it equal cur_interval -> ARM, counter cleared.
REQ-017 ARM: one cycle; latch obstacle_start_x and obstacle_trigger from the LFSR; increment spawn_count; -> ACTIVE.
REQ-018 ACTIVE: obstacle_trigger and obstacle_start_x held stable; obstacle_done -> WAIT with obstacle_trigger = 0 next cycle.
REQ-019 enable=0 in any state SHALL force IDLE next cycle with obstacle_trigger = 0; enable has priority over obstacle_done and frame_tick.
REQ-020 frame_tick SHALL be ignored in IDLE, ARM and ACTIVE; obstacle_done SHALL be ignored outside ACTIVE.
REQ-021 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock after reset; never reaches zero.
REQ-022 Lane selection: v = lfsr[6:2] (0..31); lane = v if v<20, else v-20; obstacle_start_x = lane*32, range 0..608.
REQ-023 Type selection: t = lfsr[1:0]; obstacle_trigger = t if t!=0, else 1.
REQ-024 Difficulty: in ARM, when (spawn_count+1) mod LEVEL_STEP == 0 and cur_interval > MIN_INTERVAL, cur_interval SHALL decrement by 1; it never goes below MIN_INTERVAL.
REQ-025 spawn_count SHALL wrap 255 -> 0; wrap has no other effect.
REQ-026 Spawn latency SHALL be exactly cur_interval frame_ticks after WAIT entry plus 1 clock for ARM.

Reset
REQ-027 Reset SHALL act immediately, without a clock edge: state IDLE, obstacle_trigger=0, obstacle_start_x=0, spawn_count=0, cur_interval=SPAWN_INTERVAL, frame counter=0, LFSR=LFSR_SEED.
REQ-028 Reset asserted mid-ACTIVE SHALL drop obstacle_trigger to 0 asynchronously; the first action after release is evaluation of enable in IDLE.

Structure
REQ-029 Screen width 640, obstacle width 32, lane count 20, state encoding, and the LFSR tap mask SHALL live in the shared game package.
REQ-030 The LFSR SHALL be a sub-module named lfsr16 (ports: clock, reset, seed, value); the rest SHALL be flat.

Verification
REQ-031 Reset, then enable=1 with SPAWN_INTERVAL=4 and 4 frame_ticks -> ARM after the 4th tick; obstacle_trigger nonzero one cycle later; spawn_count=1.
REQ-032 Force LFSR to a value with lfsr[6:2]=23 and lfsr[1:0]=0 -> obstacle_start_x=96, obstacle_trigger=1.
REQ-033 In ACTIVE, 100 frame_ticks with no obstacle_done -> outputs unchanged; obstacle_done pulse -> obstacle_trigger=0 next cycle; state WAIT.
REQ-034 LEVEL_STEP=8, SPAWN_INTERVAL=22, MIN_INTERVAL=20, 40 spawn/done cycles -> cur_interval 21 after spawn 8, 20 after spawn 16, stays 20 thereafter.
REQ-035 enable dropped in the same cycle as obstacle_done in ACTIVE -> IDLE, obstacle_trigger=0, cur_interval retained.
REQ-036 Assert reset between clock edges mid-ACTIVE -> obstacle_trigger=0 before the next edge; all outputs take their REQ-027 values.
